bnn_inference_scheduler: RTL and testbench

// Sequences one BNN inference per received image. Sits between system_controller
// (start/result handshake) and the shared BNN compute engine (per-layer start/done).

---
 rtl/bnn_inference_scheduler_pkg.sv | 17 +
 rtl/bnn_inference_scheduler_if.sv | 34 +++
 rtl/bnn_inference_scheduler_argmax.sv | 47 ++++
 rtl/bnn_inference_scheduler.sv | 146 ++++++++++++++
 tb/tb_bnn_inference_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_inference_scheduler_pkg.sv
// Shared scheduler definitions: FSM state type and class-index sizing.
// Also imported by system_controller.
package bnn_pkg;

    localparam int unsigned CLASS_W         = 4;
    localparam int unsigned BNN_NUM_CLASSES = 10;

    typedef enum logic [2:0] {
        IDLE,
        L_START,
        L_WAIT,
        SCORES,
        RESULT,
        ERROR
    } sched_state_t;

endpackage

// File: rtl/bnn_inference_scheduler_if.sv
// Handshake bundle between the scheduler, the system controller and the compute engine.
// master = scheduler side, slave = controller/engine side.
interface bnn_inference_scheduler_if
#(
    parameter int unsigned LIDX_W  = 2,
    parameter int unsigned SCORE_W = 8
) ();
    import bnn_pkg::*;

    logic                      start;
    logic                      abort;
    logic                      busy;
    logic                      layer_start;
    logic [LIDX_W-1:0]         layer_idx;
    logic                      layer_done;
    logic                      score_valid;
    logic signed [SCORE_W-1:0] score_data;
    logic                      score_last;
    logic [CLASS_W-1:0]        result_out;
    logic                      result_ready;
    logic                      result_ack;
    logic                      error;

    modport master (
        input  start, abort, layer_done, score_valid, score_data, score_last, result_ack,
        output busy, layer_start, layer_idx, result_out, result_ready, error
    );

    modport slave (
        output start, abort, layer_done, score_valid, score_data, score_last, result_ack,
        input  busy, layer_start, layer_idx, result_out, result_ready, error
    );

endinterface

// File: rtl/bnn_inference_scheduler_argmax.sv
// Streaming signed max/argmax over class scores; ties keep the lowest index.
// o_idx_nxt exposes the winner including the current beat so the last beat can be reported.
module bnn_argmax
    import bnn_pkg::*;
#(
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned NUM_CLASSES = BNN_NUM_CLASSES,
    parameter int unsigned CNT_W       = $clog2(NUM_CLASSES + 2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_valid,
    input  logic signed [SCORE_W-1:0] i_data,
    output logic [CLASS_W-1:0]        o_idx,
    output logic [CLASS_W-1:0]        o_idx_nxt,
    output logic [CNT_W-1:0]          o_count
);

    logic signed [SCORE_W-1:0] r_max;
    logic [CLASS_W-1:0]        r_idx;
    logic [CNT_W-1:0]          r_count;
    logic                      w_take;

    always_comb begin
        w_take    = (r_count == '0) || (i_data > r_max);
        o_idx_nxt = w_take ? CLASS_W'(r_count) : r_idx;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_max   <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else if (i_valid) begin
            r_count <= r_count + CNT_W'(1);
            if (w_take) begin
                r_max <= i_data;
                r_idx <= CLASS_W'(r_count);
            end
        end
    end

    assign o_idx   = r_idx;
    assign o_count = r_count;

endmodule

// File: rtl/bnn_inference_scheduler.sv
// Per-image BNN inference sequencer: steps the engine through NUM_LAYERS layers,
// reduces streamed class scores to an argmax digit, latches watchdog/protocol errors.
module bnn_inference_scheduler
    import bnn_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = 3,
    parameter int unsigned NUM_CLASSES    = BNN_NUM_CLASSES,
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    bnn_inference_scheduler_if.master  bus
);

    localparam int unsigned LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_W  = $clog2(NUM_CLASSES + 2);
    localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [WD_W-1:0]   WD_MAX     = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(NUM_CLASSES);

    sched_state_t        r_state;
    logic                r_busy;
    logic                r_layer_start;
    logic [LIDX_W-1:0]   r_layer_idx;
    logic [CLASS_W-1:0]  r_result_out;
    logic                r_result_ready;
    logic                r_error;
    logic [WD_W-1:0]     r_wd;

    logic                w_beat;
    logic                w_clear;
    logic [CLASS_W-1:0]  w_idx;
    logic [CLASS_W-1:0]  w_idx_nxt;
    logic [CNT_W-1:0]    w_count;

    assign w_beat  = (r_state == SCORES) && bus.score_valid;
    assign w_clear = (r_state != SCORES) || bus.abort;

    bnn_argmax #(
        .SCORE_W     (SCORE_W),
        .NUM_CLASSES (NUM_CLASSES),
        .CNT_W       (CNT_W)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_valid   (w_beat),
        .i_data    (bus.score_data),
        .o_idx     (w_idx),
        .o_idx_nxt (w_idx_nxt),
        .o_count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_layer_start  <= 1'b0;
            r_layer_idx    <= '0;
            r_result_out   <= '0;
            r_result_ready <= 1'b0;
            r_error        <= 1'b0;
            r_wd           <= '0;
        end else if (bus.abort) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_layer_start  <= 1'b0;
            r_layer_idx    <= '0;
            r_result_ready <= 1'b0;
            r_error        <= 1'b0;
            r_wd           <= '0;
        end else begin
            r_layer_start <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state       <= L_START;
                    r_busy        <= 1'b1;
                    r_layer_start <= 1'b1;
                    r_layer_idx   <= '0;
                    r_wd          <= '0;
                end
                L_START: begin
                    r_state <= L_WAIT;
                    r_wd    <= '0;
                end
                L_WAIT: begin
                    // progress on the expiry cycle takes precedence over the timeout
                    if (bus.layer_done) begin
                        r_wd <= '0;
                        if (r_layer_idx == LAST_LAYER) begin
                            r_state <= SCORES;
                        end else begin
                            r_layer_idx   <= r_layer_idx + LIDX_W'(1);
                            r_layer_start <= 1'b1;
                            r_state       <= L_START;
                        end
                    end else if (r_wd == WD_MAX) begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                SCORES: begin
                    if (bus.score_valid) begin
                        r_wd <= '0;
                        if (bus.score_last && w_count == CNT_LAST) begin
                            r_result_out   <= w_idx_nxt;
                            r_result_ready <= 1'b1;
                            r_state        <= RESULT;
                        end else if (bus.score_last || w_count == CNT_FULL) begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end
                    end else if (r_wd == WD_MAX) begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                RESULT: if (bus.result_ack) begin
                    r_result_ready <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= IDLE;
                end
                ERROR: ;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.layer_start  = r_layer_start;
    assign bus.layer_idx    = r_layer_idx;
    assign bus.result_out   = r_result_out;
    assign bus.result_ready = r_result_ready;
    assign bus.error        = r_error;

    logic w_unused;
    assign w_unused = ^w_idx;

endmodule

// File: tb/tb_bnn_inference_scheduler.sv
// Self-checking bench: score-vector table, randomized inferences against an argmax
// model, and directed handshake/protocol/timeout/reset sequences.
module tb_bnn_inference_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bnn_inference_scheduler_if #(.LIDX_W(2), .SCORE_W(8)) bus ();

    bnn_inference_scheduler #(
        .NUM_LAYERS     (3),
        .NUM_CLASSES    (10),
        .SCORE_W        (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef logic signed [7:0] score_arr_t [16];

    typedef struct {
        string name;
        int    s [10];
        int    exp;
    } vec_t;

    vec_t vecs [5];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   ls_count = 0;

    always @(negedge clk) if (bus.layer_start) ls_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ls(input int idx, input string name);
        int k = 0;
        while (!bus.layer_start && k < 40) begin
            tick();
            k++;
        end
        check({name, "_ls_seen"}, int'(bus.layer_start), 1);
        check({name, "_ls_idx"}, int'(bus.layer_idx), idx);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_done();
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    // Engine model: observe each layer_start, answer with layer_done a few cycles later.
    task automatic run_layers(input bit rnd, input string name);
        for (int l = 0; l < 3; l++) begin
            wait_ls(l, name);
            tick();
            check({name, "_ls_1cyc"}, int'(bus.layer_start), 0);
            repeat (rnd ? $urandom_range(0, 8) : 3) tick();
            pulse_done();
        end
    endtask

    task automatic send_beats(input score_arr_t s, input int n, input int last_at, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) repeat ($urandom_range(0, 3)) tick();
            bus.score_valid = 1'b1;
            bus.score_data  = s[i];
            bus.score_last  = (i == last_at);
            tick();
            bus.score_valid = 1'b0;
            bus.score_last  = 1'b0;
        end
    endtask

    task automatic full_inf(input score_arr_t s, input int exp, input string name,
                            input bit rnd, input bit do_ack);
        pulse_start();
        run_layers(rnd, name);
        send_beats(s, 10, 9, rnd);
        check({name, "_ready"}, int'(bus.result_ready), 1);
        check({name, "_result"}, int'(bus.result_out), exp);
        if (do_ack) begin
            bus.result_ack = 1'b1;
            tick();
            bus.result_ack = 1'b0;
            check({name, "_ack_busy"}, int'(bus.busy), 0);
            check({name, "_ack_ready"}, int'(bus.result_ready), 0);
        end
    endtask

    function automatic int ref_argmax(input score_arr_t s);
        int best = 0;
        for (int i = 1; i < 10; i++)
            if (s[i] > s[best]) best = i;
        return best;
    endfunction

    initial begin
        score_arr_t sa;
        int         base;
        int         stable;

        vecs[0] = '{"nominal",  '{3, -2, 7, 1, 0, -8, 7, 2, 4, 5}, 2};
        vecs[1] = '{"neg_tie",  '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -127}, 9};
        vecs[2] = '{"all_eq",   '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5}, 0};
        vecs[3] = '{"first_hi", '{127, 126, -1, 127, 0, 0, 0, 0, 0, 127}, 0};
        vecs[4] = '{"desc_neg", '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1}, 9};

        bus.start = 0; bus.abort = 0; bus.layer_done = 0; bus.score_valid = 0;
        bus.score_data = '0; bus.score_last = 0; bus.result_ack = 0;
        foreach (sa[i]) sa[i] = '0;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ls", int'(bus.layer_start), 0);
        check("rst_idx", int'(bus.layer_idx), 0);
        check("rst_result", int'(bus.result_out), 0);
        check("rst_ready", int'(bus.result_ready), 0);
        check("rst_error", int'(bus.error), 0);

        // Stray engine/stream/ack activity in IDLE is ignored
        bus.layer_done = 1; bus.score_valid = 1; bus.score_last = 1; bus.result_ack = 1;
        tick();
        bus.layer_done = 0; bus.score_valid = 0; bus.score_last = 0; bus.result_ack = 0;
        tick();
        check("idle_ignore_busy", int'(bus.busy), 0);
        check("idle_ignore_err", int'(bus.error), 0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 10; i++) sa[i] = 8'(vecs[v].s[i]);
            base = ls_count;
            full_inf(sa, vecs[v].exp, vecs[v].name, 1'b0, 1'b1);
            check({vecs[v].name, "_ls_total"}, ls_count - base, 3);
        end

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 10; i++)
                sa[i] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'(int'($urandom_range(0, 6)) - 3);
            full_inf(sa, ref_argmax(sa), "rand", 1'b1, 1'b1);
        end

        // Result held while unacknowledged; start in RESULT ignored
        for (int i = 0; i < 10; i++) sa[i] = 8'(vecs[0].s[i]);
        full_inf(sa, 2, "hs", 1'b0, 1'b0);
        base   = ls_count;
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 5);
            tick();
            if (bus.result_ready !== 1'b1 || bus.result_out !== 4'd2 || bus.busy !== 1'b1) stable = 0;
        end
        bus.start = 1'b0;
        check("hs_stable", stable, 1);
        check("hs_no_ls", ls_count - base, 0);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        check("hs_ack_ready", int'(bus.result_ready), 0);
        check("hs_ack_busy", int'(bus.busy), 0);
        check("hs_ack_result", int'(bus.result_out), 2);

        // Early score_last
        pulse_start();
        run_layers(1'b0, "short");
        send_beats(sa, 9, 8, 1'b0);
        check("short_error", int'(bus.error), 1);
        check("short_ready", int'(bus.result_ready), 0);
        repeat (3) tick();
        check("short_err_held", int'(bus.error), 1);
        check("short_busy", int'(bus.busy), 1);
        pulse_abort();
        check("short_abort_err", int'(bus.error), 0);
        check("short_abort_busy", int'(bus.busy), 0);
        check("short_abort_result", int'(bus.result_out), 2);

        // Eleventh beat without last
        pulse_start();
        run_layers(1'b0, "long");
        send_beats(sa, 10, -1, 1'b0);
        check("long_10_noerr", int'(bus.error), 0);
        send_beats(sa, 1, -1, 1'b0);
        check("long_11_error", int'(bus.error), 1);
        pulse_abort();
        check("long_abort_err", int'(bus.error), 0);

        // Watchdog expiry: layer_start cycle c, error first visible at c+17
        pulse_start();
        wait_ls(0, "to");
        repeat (16) tick();
        check("to_before", int'(bus.error), 0);
        tick();
        check("to_expired", int'(bus.error), 1);
        pulse_abort();
        check("to_abort_err", int'(bus.error), 0);

        // layer_done on the expiry cycle still counts as progress
        pulse_start();
        wait_ls(0, "to_edge");
        repeat (16) tick();
        pulse_done();
        check("to_edge_noerr", int'(bus.error), 0);
        wait_ls(1, "to_edge_next");
        pulse_abort();
        check("to_edge_abort_busy", int'(bus.busy), 0);

        // Reset during L_WAIT of layer 1
        pulse_start();
        wait_ls(0, "rmid");
        tick();
        repeat (3) tick();
        pulse_done();
        wait_ls(1, "rmid1");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_busy", int'(bus.busy), 0);
        check("rmid_ls", int'(bus.layer_start), 0);
        check("rmid_idx", int'(bus.layer_idx), 0);
        check("rmid_result", int'(bus.result_out), 0);
        check("rmid_ready", int'(bus.result_ready), 0);
        check("rmid_error", int'(bus.error), 0);
        base = ls_count;
        repeat (5) tick();
        check("rmid_no_ls", ls_count - base, 0);
        for (int i = 0; i < 10; i++) sa[i] = 8'(vecs[1].s[i]);
        full_inf(sa, 9, "rmid_restart", 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
